truth_table_sweeper: RTL and testbench

Sequencer that characterises one 3-input combinational logic gate (`{in1, in2, in3}` -> `out`).
- Steps the gate's inputs through all 8 vectors (000..111), waits a settle interval per vector, samples the gate output, and assembles the observed 8-bit truth-table code.
- The code uses the same MSB-first ordering as the gate module names (0xFE = output 1 for every vector except 111).
- Compares the code against an expected code and reports match plus a per-bit mismatch mask.
- Sits between the test/configuration controller and a gate instance under characterisation.

---
 rtl/truth_table_sweeper.sv | 118 +++++++++++
 tb/tb_truth_table_sweeper.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through vectors 000..111, samples its output after a
// settle interval per vector and reports the observed truth-table code.
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       abort,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       out_sample,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_code,
    output logic       match,
    output logic [7:0] mismatch_mask
);

    // state  | meaning
    // IDLE   | waiting for start; vector 000 driven
    // SETTLE | driving vector v, counter runs down to 0, then sample
    // DONE   | one cycle, done pulse, results committed
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_n;
    logic [2:0] v, v_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] exp_q, exp_n;
    logic [7:0] work, work_n;
    logic [7:0] table_n, mask_n;
    logic       match_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            v             <= 3'd0;
            cnt           <= 8'd0;
            exp_q         <= 8'd0;
            work          <= 8'd0;
            table_code    <= 8'd0;
            match         <= 1'b0;
            mismatch_mask <= 8'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            v             <= v_n;
            cnt           <= cnt_n;
            exp_q         <= exp_n;
            work          <= work_n;
            table_code    <= table_n;
            match         <= match_n;
            mismatch_mask <= mask_n;
            busy          <= (state_n == SETTLE);
            done          <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n = state;
        v_n     = v;
        cnt_n   = cnt;
        exp_n   = exp_q;
        work_n  = work;
        table_n = table_code;
        match_n = match;
        mask_n  = mismatch_mask;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETTLE;
                    v_n     = 3'd0;
                    cnt_n   = RELOAD;
                    exp_n   = expected;
                    work_n  = 8'd0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_n = IDLE;
                    v_n     = 3'd0;
                    cnt_n   = 8'd0;
                    work_n  = 8'd0;
                end else if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else begin
                    // vector v lands in bit 7-v so the code reads MSB-first
                    work_n[3'd7 - v] = out_sample;
                    if (v == 3'd7) begin
                        state_n = DONE;
                        v_n     = 3'd0;
                        table_n = work_n;
                        match_n = (work_n == exp_q);
                        mask_n  = work_n ^ exp_q;
                    end else begin
                        v_n   = v + 3'd1;
                        cnt_n = RELOAD;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // v is forced back to 000 whenever SETTLE is left, so it drives the gate directly
    assign {in1, in2, in3} = v;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 2 and settle 1) driving
// gate models, checked every cycle against a sweep-timeline model.
module tb_truth_table_sweeper;

    localparam int S0 = 2;
    localparam int S1 = 1;
    localparam int G_NAND = 0, G_AND = 1, G_NOR = 2, G_XOR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       start_d [2];
    logic       abort_d [2];
    int         gsel [2];

    logic [2:0] vec_d [2];
    logic       busy_d [2], done_d [2], match_d [2];
    logic [7:0] tab_d [2], mask_d [2];
    logic       out_s0, out_s1;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // model: sweep progress as cycles elapsed since the accepted start
    logic       m_act [2], m_done [2], m_match [2];
    int         m_k [2];
    logic [7:0] m_exp [2], m_work [2], m_tab [2], m_mask [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gate(input int sel, input logic [2:0] v);
        case (sel)
            G_NAND:  return (v != 3'd7);
            G_AND:   return (v == 3'd7);
            G_NOR:   return (v == 3'd0);
            default: return ^v;
        endcase
    endfunction

    assign out_s0 = gate(gsel[0], vec_d[0]);
    assign out_s1 = gate(gsel[1], vec_d[1]);

    truth_table_sweeper #(.SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .reset(reset), .start(start_d[0]), .expected(expected),
        .abort(abort_d[0]), .in1(vec_d[0][2]), .in2(vec_d[0][1]), .in3(vec_d[0][0]),
        .out_sample(out_s0), .busy(busy_d[0]), .done(done_d[0]),
        .table_code(tab_d[0]), .match(match_d[0]), .mismatch_mask(mask_d[0])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .reset(reset), .start(start_d[1]), .expected(expected),
        .abort(abort_d[1]), .in1(vec_d[1][2]), .in2(vec_d[1][1]), .in3(vec_d[1][0]),
        .out_sample(out_s1), .busy(busy_d[1]), .done(done_d[1]),
        .table_code(tab_d[1]), .match(match_d[1]), .mismatch_mask(mask_d[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic mstep(input int i, input int s, input logic st, input logic ab);
        logic was_done;
        int   v;
        was_done  = m_done[i];
        m_done[i] = 1'b0;
        if (m_act[i]) begin
            if (ab) begin
                m_act[i] = 1'b0;
            end else begin
                m_k[i]++;
                if (m_k[i] % s == 0) begin
                    v = m_k[i] / s - 1;
                    m_work[i][7-v] = gate(gsel[i], 3'(v));
                    if (v == 7) begin
                        m_act[i]   = 1'b0;
                        m_done[i]  = 1'b1;
                        m_tab[i]   = m_work[i];
                        m_match[i] = (m_work[i] == m_exp[i]);
                        m_mask[i]  = m_work[i] ^ m_exp[i];
                    end
                end
            end
        end else if (!was_done && st) begin
            m_act[i]  = 1'b1;
            m_k[i]    = 0;
            m_exp[i]  = expected;
            m_work[i] = 8'h00;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0; m_done[i] = 1'b0; m_match[i] = 1'b0; m_k[i] = 0;
                m_exp[i] = 8'h00; m_work[i] = 8'h00; m_tab[i] = 8'h00; m_mask[i] = 8'h00;
            end
        end else begin
            mstep(0, S0, start_d[0], abort_d[0]);
            mstep(1, S1, start_d[1], abort_d[1]);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [2:0] ev;
            ev = m_act[i] ? 3'(m_k[i] / (i == 0 ? S0 : S1)) : 3'd0;
            check(i == 0 ? "cmp0" : "cmp1",
                  {10'd0, busy_d[i], done_d[i], vec_d[i], tab_d[i], match_d[i], mask_d[i]},
                  {10'd0, m_act[i], m_done[i], ev, m_tab[i], m_match[i], m_mask[i]});
        end
    end

    task automatic sweep(input int i, input logic [7:0] ex, input int g, output int lat);
        int e0;
        gsel[i] = g;
        expected = ex;
        @(negedge clk); start_d[i] = 1'b1;
        @(negedge clk); start_d[i] = 1'b0;
        e0 = cyc;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (done_d[i]) begin
                lat = cyc - e0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic start_only(input int i, input logic [7:0] ex, input int g);
        gsel[i] = g;
        expected = ex;
        @(negedge clk); start_d[i] = 1'b1;
        @(negedge clk); start_d[i] = 1'b0;
    endtask

    task automatic wait_vec(input int i, input logic [2:0] t, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (vec_d[i] == t) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check(nm, 32'd0, 32'd1);
    endtask

    task automatic count_done(input int i, input int ncyc, output int nd);
        nd = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (done_d[i]) nd++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int  lat, nd;
        bit  dropped;
        start_d = '{1'b0, 1'b0};
        abort_d = '{1'b0, 1'b0};
        gsel    = '{G_NAND, G_NAND};
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst0", {busy_d[0], done_d[0], vec_d[0], tab_d[0], match_d[0], mask_d[0]}, 32'd0);
        check("rst1", {busy_d[1], done_d[1], vec_d[1], tab_d[1], match_d[1], mask_d[1]}, 32'd0);

        // NAND3, settle 2
        sweep(0, 8'hFE, G_NAND, lat);
        check("t1_lat", lat, 16);
        check("t1_table", tab_d[0], 8'hFE);
        check("t1_match", match_d[0], 1'b1);
        check("t1_mask", mask_d[0], 8'h00);

        // AND3 against NAND code, then against its own code
        sweep(0, 8'hFE, G_AND, lat);
        check("t2_table", tab_d[0], 8'h01);
        check("t2_match", match_d[0], 1'b0);
        check("t2_mask", mask_d[0], 8'hFF);
        sweep(0, 8'h01, G_AND, lat);
        check("t2b_match", match_d[0], 1'b1);
        check("t2b_mask", mask_d[0], 8'h00);

        // NOR3, settle 1
        sweep(1, 8'h80, G_NOR, lat);
        check("t3_lat", lat, 8);
        check("t3_table", tab_d[1], 8'h80);
        check("t3_match", match_d[1], 1'b1);

        // start held high through busy and DONE
        gsel[1] = G_NOR;
        expected = 8'h80;
        @(negedge clk); start_d[1] = 1'b1;
        nd = 0;
        dropped = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (nd == 1 && !dropped) begin
                start_d[1] = 1'b0;
                dropped = 1'b1;
            end
            if (done_d[1]) nd++;
        end
        start_d[1] = 1'b0;
        check("t3_held_sweeps", nd, 1);
        check("t3_held_idle", busy_d[1], 1'b0);

        // abort during vector 100
        sweep(0, 8'hFE, G_NAND, lat);
        check("t4_pre_match", match_d[0], 1'b1);
        start_only(0, 8'h00, G_XOR);
        wait_vec(0, 3'b100, "t4_wait_timeout");
        abort_d[0] = 1'b1;
        @(negedge clk); abort_d[0] = 1'b0;
        check("t4_busy", busy_d[0], 1'b0);
        check("t4_vec", vec_d[0], 3'b000);
        check("t4_done", done_d[0], 1'b0);
        check("t4_table", tab_d[0], 8'hFE);
        check("t4_match", match_d[0], 1'b1);
        count_done(0, 20, nd);
        check("t4_no_done", nd, 0);

        // asynchronous reset during vector 010
        start_only(0, 8'hFE, G_NAND);
        wait_vec(0, 3'b010, "t5_wait_timeout");
        #2 reset = 1'b1;
        #1 check("t5_async", {busy_d[0], done_d[0], vec_d[0], tab_d[0], match_d[0], mask_d[0]}, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        sweep(0, 8'hFE, G_NAND, lat);
        check("t5_lat", lat, 16);
        check("t5_table", tab_d[0], 8'hFE);
        check("t5_match", match_d[0], 1'b1);

        // abort coincident with the final sample
        start_only(0, 8'hFE, G_XOR);
        wait_vec(0, 3'b111, "t6_wait_timeout");
        @(negedge clk);
        abort_d[0] = 1'b1;
        @(negedge clk); abort_d[0] = 1'b0;
        check("t6_busy", busy_d[0], 1'b0);
        check("t6_done", done_d[0], 1'b0);
        check("t6_table", tab_d[0], 8'hFE);
        count_done(0, 10, nd);
        check("t6_no_done", nd, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
